// File: rtl/one_to_three_tx.sv
// Frame replicator: buffers one input frame and emits it three times, stamping the copy number
// into the ID byte. Define ONE_TO_THREE_TX_FRAMECNT_EN to carry a 4-bit frame counter in ID[7:4].
module one_to_three_tx #(
    parameter int WHEREISID = 0,
    parameter int IFG       = 12,
    parameter int ADDR_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_w,
    input  logic [7:0] txdata_w,
    output logic [7:0] data_out,
    output logic       en_out,
    output logic       busy,
    output logic       dropped
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;
    localparam logic [1:0] S_SEND    = 2'd3;

    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ID_POS   = (ADDR_W+1)'(WHEREISID);
    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [7:0]      IFG_LAST = 8'(IFG - 1);

    logic [1:0]        state;
    logic              tx_en_p0;
    logic              tx_en_p1;
    logic [7:0]        txdata_p0;
    logic              rising;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   rd_ptr;
    logic [2:0]        copy;
    logic [7:0]        gap_cnt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              vld_p1;
    logic [7:0]        rd_data_p1;
    logic              rd_id_p1;
    logic [1:0]        rd_copy_p1;
    logic [3:0]        id_hi;

`ifdef ONE_TO_THREE_TX_FRAMECNT_EN
    logic [3:0]        frame_cnt;
    assign id_hi = frame_cnt;
`else
    assign id_hi = rd_data_p1[7:4];
`endif

    function automatic logic [7:0] stamp_id(input logic [3:0] hi, input logic [1:0] cp);
        return {hi, 2'b00, cp};
    endfunction

    // Only a fresh rising edge starts a frame, so a frame already in flight is never joined midway.
    assign rising = tx_en_p0 & ~tx_en_p1;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = len[ADDR_W-1:0];
        if (state == S_IDLE) begin
            wr_en   = rising;
            wr_addr = '0;
        end else if (state == S_CAPTURE) begin
            wr_en = tx_en_p0 && (len != MAX_LEN);
        end
    end

    // p0: input register, then control FSM; reads are issued into p1 while in SEND
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            tx_en_p0 <= 1'b1;
            tx_en_p1 <= 1'b1;
            len      <= '0;
            rd_ptr   <= '0;
            copy     <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
            vld_p1   <= 1'b0;
`ifdef ONE_TO_THREE_TX_FRAMECNT_EN
            frame_cnt <= '0;
`endif
        end else begin
            tx_en_p0 <= tx_en_w;
            tx_en_p1 <= tx_en_p0;
            dropped  <= 1'b0;
            vld_p1   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rising) begin
                        len   <= LEN_ONE;
                        busy  <= 1'b1;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (tx_en_p0) begin
                        if (len != MAX_LEN) len <= len + LEN_ONE;
                    end else if (len <= ID_POS) begin
                        dropped <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        copy    <= 3'd1;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (rising) dropped <= 1'b1;
                    if (gap_cnt == IFG_LAST) begin
                        rd_ptr <= '0;
                        if (copy <= 3'd3) begin
                            state <= S_SEND;
                        end else begin
                            busy  <= 1'b0;
                            copy  <= '0;
                            state <= S_IDLE;
`ifdef ONE_TO_THREE_TX_FRAMECNT_EN
                            frame_cnt <= frame_cnt + 4'd1;
`endif
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    if (rising) dropped <= 1'b1;
                    vld_p1 <= 1'b1;
                    if (rd_ptr == len - LEN_ONE) begin
                        copy    <= copy + 3'd1;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        rd_ptr <= rd_ptr + LEN_ONE;
                    end
                end
            endcase
        end
    end

    // p0 data capture into the buffer and p1 synchronous buffer read
    always_ff @(posedge clk) begin
        txdata_p0 <= txdata_w;
        if (wr_en) mem[wr_addr] <= txdata_p0;
        rd_data_p1 <= mem[rd_ptr[ADDR_W-1:0]];
        rd_id_p1   <= (rd_ptr == ID_POS);
        rd_copy_p1 <= copy[1:0];
    end

    // p2: output register; data is forced to zero whenever it is not valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out   <= 1'b0;
            data_out <= '0;
        end else begin
            en_out <= vld_p1;
            if (!vld_p1)
                data_out <= '0;
            else if (rd_id_p1)
                data_out <= stamp_id(id_hi, rd_copy_p1);
            else
                data_out <= rd_data_p1;
        end
    end

endmodule
